// File: rtl/wgt_pkg.sv
// Shared definitions for the weight shift-RF loader.
//   state_t        : loader FSM states (IDLE / LOAD / REPLAY / DONE)
//   DEF_*          : default parameter values for the loader and its counters
//   rep_cnt_width  : width of the replay-shift counter, wide enough for
//                    num_passes * buffer_size issued shifts
package wgt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REPLAY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_BUFFER_SIZE = 27;
  localparam int DEF_ADDR_WIDTH  = 12;
  localparam int DEF_PASS_WIDTH  = 8;

  function automatic int rep_cnt_width(input int pass_width, input int buf_size);
    return pass_width + $clog2(buf_size);
  endfunction

endpackage

// File: rtl/wgt_rf_loader_ctr.sv
// Load-cycle and replay-shift counters for the weight RF loader.
// Ports:
//   clk, rst_n    clock / synchronous active-low reset
//   clr           clear both counters (held while the loader is idle)
//   load_inc      count one LOAD cycle
//   rep_inc       request one replay shift (ignored once the target is reached)
//   num_passes    captured pass count; target = num_passes * BUFFER_SIZE shifts
//   load_rd_last  current LOAD cycle issues the last SRAM read
//   load_end      current LOAD cycle is the last one (holds the last load shift)
//   rep_end       all replay shifts have been issued
module wgt_rf_loader_ctr
  import wgt_pkg::*;
#(
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int PASS_WIDTH  = DEF_PASS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load_inc,
  input  logic                  rep_inc,
  input  logic [PASS_WIDTH-1:0] num_passes,
  output logic                  load_rd_last,
  output logic                  load_end,
  output logic                  rep_end
);

  // LOAD spans BUFFER_SIZE+2 cycles, so the counter must reach BUFFER_SIZE+1.
  localparam int LW = $clog2(BUFFER_SIZE + 3);
  localparam int RW = rep_cnt_width(PASS_WIDTH, BUFFER_SIZE);

  logic [LW-1:0] load_cnt;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_total;

  assign rep_total    = RW'(num_passes) * RW'(BUFFER_SIZE);
  assign load_rd_last = (load_cnt == LW'(BUFFER_SIZE - 1));
  assign load_end     = (load_cnt == LW'(BUFFER_SIZE + 1));
  assign rep_end      = (rep_cnt == rep_total);

  // Counter state: both counters saturate at their terminal value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= {LW{1'b0}};
      rep_cnt  <= {RW{1'b0}};
    end else if (clr) begin
      load_cnt <= {LW{1'b0}};
      rep_cnt  <= {RW{1'b0}};
    end else begin
      if (load_inc && !load_end) begin
        load_cnt <= load_cnt + LW'(1);
      end else begin
        load_cnt <= load_cnt;
      end
      if (rep_inc && !rep_end) begin
        rep_cnt <= rep_cnt + RW'(1);
      end else begin
        rep_cnt <= rep_cnt;
      end
    end
  end

endmodule

// File: rtl/wgt_rf_loader.sv
// Transmit side of the weight shift-RF interface. Fetches BUFFER_SIZE weights
// from SRAM, shifts them into the RF with select_wgt=1, then issues
// recirculating shifts (select_wgt=0) so the RF streams the set num_passes times.
// Ports:
//   clk, rst_n       clock / synchronous active-low reset
//   start            1-cycle request, sampled only in IDLE (captures base_addr, num_passes)
//   abort            return to IDLE on the next cycle from any state
//   base_addr        SRAM address of word 0
//   num_passes       number of replay passes (0 = load only)
//   replay_en        consumer ready; one replay shift per cycle while high
//   mem_rd_en        SRAM read strobe
//   mem_addr         SRAM read address
//   mem_rd_data      SRAM data, valid one cycle after mem_rd_en
//   select_wgt       to RF: 1 = load data_out, 0 = recirculate
//   wgt_RF_shift_en  to RF shift enable
//   data_out         to RF data_in
//   rf_data_valid    RF output holds a replayed weight this cycle
//   busy             high in LOAD, REPLAY and DONE
//   done             1-cycle completion pulse
module wgt_rf_loader
  import wgt_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int PASS_WIDTH  = DEF_PASS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [PASS_WIDTH-1:0] num_passes,
  input  logic                  replay_en,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  select_wgt,
  output logic                  wgt_RF_shift_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rf_data_valid,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [PASS_WIDTH-1:0] passes;
  logic                  rd_pending;   // SRAM data arrives this cycle
  logic                  load_rd_last;
  logic                  load_end;
  logic                  rep_end;
  logic                  ctr_clr;
  logic                  load_inc;
  logic                  rep_inc;

  assign ctr_clr  = (state == ST_IDLE);
  assign load_inc = (state == ST_LOAD);
  assign rep_inc  = (state == ST_REPLAY) && replay_en;

  wgt_rf_loader_ctr #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .PASS_WIDTH  (PASS_WIDTH)
  ) u_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (ctr_clr),
    .load_inc     (load_inc),
    .rep_inc      (rep_inc),
    .num_passes   (passes),
    .load_rd_last (load_rd_last),
    .load_end     (load_end),
    .rep_end      (rep_end)
  );

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      state           <= ST_IDLE;
      passes          <= rst_n ? passes : {PASS_WIDTH{1'b0}};
      rd_pending      <= 1'b0;
      mem_rd_en       <= 1'b0;
      mem_addr        <= {ADDR_WIDTH{1'b0}};
      select_wgt      <= 1'b0;
      wgt_RF_shift_en <= 1'b0;
      data_out        <= {DATA_WIDTH{1'b0}};
      rf_data_valid   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          rd_pending      <= 1'b0;
          select_wgt      <= 1'b0;
          wgt_RF_shift_en <= 1'b0;
          data_out        <= {DATA_WIDTH{1'b0}};
          rf_data_valid   <= 1'b0;
          done            <= 1'b0;
          if (start) begin
            state     <= ST_LOAD;
            passes    <= num_passes;
            mem_rd_en <= 1'b1;
            mem_addr  <= base_addr;
            busy      <= 1'b1;
          end else begin
            state     <= ST_IDLE;
            passes    <= passes;
            mem_rd_en <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
            busy      <= 1'b0;
          end
        end

        ST_LOAD: begin
          busy          <= 1'b1;
          rf_data_valid <= 1'b0;
          // Read k is issued in LOAD cycle k; its data is registered one
          // cycle later, so the matching load shift appears in cycle k+2.
          rd_pending    <= mem_rd_en;
          if (mem_rd_en && !load_rd_last) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);   // wraps modulo 2^ADDR_WIDTH
          end else begin
            mem_rd_en <= 1'b0;
            mem_addr  <= {ADDR_WIDTH{1'b0}};
          end
          if (rd_pending) begin
            data_out        <= mem_rd_data;
            select_wgt      <= 1'b1;
            wgt_RF_shift_en <= 1'b1;
          end else begin
            data_out        <= {DATA_WIDTH{1'b0}};
            select_wgt      <= 1'b0;
            wgt_RF_shift_en <= 1'b0;
          end
          if (load_end) begin
            if (passes == {PASS_WIDTH{1'b0}}) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_REPLAY;
              done  <= 1'b0;
            end
          end else begin
            state <= ST_LOAD;
            done  <= 1'b0;
          end
        end

        ST_REPLAY: begin
          busy          <= 1'b1;
          rd_pending    <= 1'b0;
          mem_rd_en     <= 1'b0;
          mem_addr      <= {ADDR_WIDTH{1'b0}};
          select_wgt    <= 1'b0;
          data_out      <= {DATA_WIDTH{1'b0}};
          // Only recirculating shifts are issued here, so the RF output is
          // valid exactly one cycle after each visible shift.
          rf_data_valid <= wgt_RF_shift_en;
          if (rep_end) begin
            wgt_RF_shift_en <= 1'b0;
            state           <= ST_DONE;
            done            <= 1'b1;
          end else begin
            wgt_RF_shift_en <= replay_en;
            state           <= ST_REPLAY;
            done            <= 1'b0;
          end
        end

        ST_DONE: begin
          state           <= ST_IDLE;
          rd_pending      <= 1'b0;
          mem_rd_en       <= 1'b0;
          mem_addr        <= {ADDR_WIDTH{1'b0}};
          select_wgt      <= 1'b0;
          wgt_RF_shift_en <= 1'b0;
          data_out        <= {DATA_WIDTH{1'b0}};
          rf_data_valid   <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
        end

        default: begin
          state           <= ST_IDLE;
          rd_pending      <= 1'b0;
          mem_rd_en       <= 1'b0;
          mem_addr        <= {ADDR_WIDTH{1'b0}};
          select_wgt      <= 1'b0;
          wgt_RF_shift_en <= 1'b0;
          data_out        <= {DATA_WIDTH{1'b0}};
          rf_data_valid   <= 1'b0;
          busy            <= 1'b0;
          done            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wgt_rf_loader.sv
// Self-checking bench for wgt_rf_loader (BUFFER_SIZE=4). An SRAM model with
// one-cycle latency feeds the loader and a shift-RF model consumes its
// strobes; queues hold the expected read addresses, load data and replayed
// weights, and are popped as the DUT produces them.
module tb_wgt_rf_loader;

  localparam int DW = 8;
  localparam int B  = 4;
  localparam int AW = 12;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [PW-1:0] num_passes;
  logic          replay_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          select_wgt;
  logic          wgt_RF_shift_en;
  logic [DW-1:0] data_out;
  logic          rf_data_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  wgt_rf_loader #(
    .DATA_WIDTH  (DW),
    .BUFFER_SIZE (B),
    .ADDR_WIDTH  (AW),
    .PASS_WIDTH  (PW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .num_passes      (num_passes),
    .replay_en       (replay_en),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .select_wgt      (select_wgt),
    .wgt_RF_shift_en (wgt_RF_shift_en),
    .data_out        (data_out),
    .rf_data_valid   (rf_data_valid),
    .busy            (busy),
    .done            (done)
  );

  // SRAM model: data valid the cycle after the read strobe.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) mem_rd_data <= sram[mem_addr];
  end

  // Shift-RF model: word shifted out of the tail is registered to rf_out.
  logic [DW-1:0] rf [0:B-1];
  logic [DW-1:0] rf_out;
  always @(posedge clk) begin
    if (wgt_RF_shift_en === 1'b1) begin
      rf_out <= rf[B-1];
      rf[0]  <= (select_wgt === 1'b1) ? data_out : rf[B-1];
      for (int i = 1; i < B; i++) rf[i] <= rf[i-1];
    end
  end

  logic [AW-1:0] addr_q [$];
  logic [DW-1:0] load_q [$];
  logic [DW-1:0] rep_q  [$];
  int   n_vec, n_err;
  int   rfv_cnt, shift_cnt, done_cnt;
  logic pre_replay;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (mem_rd_en === 1'b1) begin
      if (addr_q.size() > 0) check("mem_addr", mem_addr, addr_q.pop_front());
      else                   check("unexp_rd", mem_rd_en, 0);
    end
    if (wgt_RF_shift_en === 1'b1 && select_wgt === 1'b1) begin
      if (load_q.size() > 0) check("load_data", data_out, load_q.pop_front());
      else                   check("unexp_load", select_wgt, 0);
    end
    if (wgt_RF_shift_en === 1'b1 && select_wgt === 1'b0) begin
      shift_cnt++;
      check("replay_gap", pre_replay, 1);
    end
    if (rf_data_valid === 1'b1) begin
      rfv_cnt++;
      if (rep_q.size() > 0) check("replay_data", rf_out, rep_q.pop_front());
      else                  check("unexp_valid", rf_data_valid, 0);
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic cyc();
    pre_replay = replay_en;
    @(posedge clk);
    @(negedge clk);
    monitor();
  endtask

  task automatic push_op(input logic [AW-1:0] base, input logic [31:0] dat, input int n_rep);
    for (int i = 0; i < B; i++) begin
      logic [AW-1:0] a;
      a = base + AW'(i);
      sram[a] = dat[31-8*i -: 8];
      addr_q.push_back(a);
      load_q.push_back(dat[31-8*i -: 8]);
    end
    for (int i = 0; i < n_rep; i++) rep_q.push_back(dat[31-8*(i%B) -: 8]);
  endtask

  // Leaves the bench at the negedge of LOAD cycle 0.
  task automatic run_op(input logic [AW-1:0] base, input logic [PW-1:0] p);
    rfv_cnt = 0; shift_cnt = 0; done_cnt = 0;
    base_addr = base; num_passes = p; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output int k);
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      if (toggle) replay_en = ~replay_en;
      cyc();
      k++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 1);
  endtask

  task automatic check_idle_after_done();
    cyc();
    check("busy_drop", busy, 0);
    check("done_pulse", done, 0);
    check("done_once", done_cnt, 1);
    check("q_empty", addr_q.size() + load_q.size() + rep_q.size(), 0);
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; rfv_cnt = 0; shift_cnt = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0;
    num_passes = '0; replay_en = 1'b0;

    // reset
    cyc(); cyc();
    check("reset_outs", {mem_rd_en, mem_addr, select_wgt, wgt_RF_shift_en, data_out,
                         rf_data_valid, busy, done}, 0);
    rst_n = 1'b1;
    cyc();
    check("idle_outs", {mem_rd_en, busy, done, wgt_RF_shift_en}, 0);

    // load + single pass
    replay_en = 1'b1;
    push_op(12'h010, 32'hA1B2C3D4, 4);
    run_op(12'h010, 8'd1);
    check("rd_cycle0", mem_rd_en, 1);
    check("busy_load", busy, 1);
    cyc();
    check("no_shift_c1", wgt_RF_shift_en, 0);
    cyc();
    check("load_shift_c2", {wgt_RF_shift_en, select_wgt}, 2'b11);
    wait_done(40, 1'b0, k);
    check("done_cycle_p1", k + 2, 11);
    check("valid_at_done", rf_data_valid, 1);
    check("rfv_cnt_p1", rfv_cnt, 4);
    check_idle_after_done();

    // backpressure, two passes, replay_en toggling
    replay_en = 1'b0;
    push_op(12'h010, 32'hA1B2C3D4, 8);
    run_op(12'h010, 8'd2);
    wait_done(80, 1'b1, k);
    check("done_cycle_bp", k, 22);
    check("valid_at_done_bp", rf_data_valid, 1);
    check("rfv_cnt_bp", rfv_cnt, 8);
    check("shift_cnt_bp", shift_cnt, 8);
    replay_en = 1'b1;
    check_idle_after_done();

    // zero passes, start while busy ignored
    push_op(12'h100, 32'h5A6B7C8D, 0);
    run_op(12'h100, 8'd0);
    cyc();
    base_addr = 12'h200; num_passes = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(40, 1'b0, k);
    check("done_cycle_p0", k + 2, 6);
    check("rfv_cnt_p0", rfv_cnt, 0);
    check_idle_after_done();
    for (int i = 0; i < 4; i++) cyc();
    check("no_restart", busy, 0);

    // abort during replay after three shifts
    push_op(12'h010, 32'hA1B2C3D4, 2);
    run_op(12'h010, 8'd1);
    k = 0;
    while (shift_cnt < 3 && k < 40) begin cyc(); k++; end
    check("abort_reach", shift_cnt, 3);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    check("abort_strobes", {mem_rd_en, wgt_RF_shift_en, select_wgt, rf_data_valid, busy, done}, 0);
    for (int i = 0; i < 5; i++) cyc();
    check("abort_no_done", done_cnt, 0);
    check("abort_rfv", rfv_cnt, 2);
    check("abort_shifts", shift_cnt, 3);
    abort = 1'b1; start = 1'b1; base_addr = 12'h300; num_passes = 8'd1;
    cyc();
    abort = 1'b0; start = 1'b0;
    check("abort_wins", {busy, mem_rd_en}, 0);
    cyc();
    check("abort_stay_idle", busy, 0);

    // new start after abort, address wrap
    push_op(12'hFFE, 32'h11223344, 4);
    run_op(12'hFFE, 8'd1);
    wait_done(40, 1'b0, k);
    check("done_cycle_wrap", k, 11);
    check("rfv_cnt_wrap", rfv_cnt, 4);
    check_idle_after_done();

    // reset mid-LOAD
    addr_q.push_back(12'h010); addr_q.push_back(12'h011); addr_q.push_back(12'h012);
    load_q.push_back(8'hA1);
    run_op(12'h010, 8'd1);
    cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    check("reset_mid_load", {mem_rd_en, mem_addr, select_wgt, wgt_RF_shift_en, data_out,
                             rf_data_valid, busy, done}, 0);
    rst_n = 1'b1;
    cyc(); cyc();
    check("idle_after_rst", {busy, mem_rd_en, wgt_RF_shift_en, done}, 0);
    check("q_empty_rst", addr_q.size() + load_q.size() + rep_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
